bcd2ex3_seq: RTL and testbench



---
 rtl/bcd2ex3_seq.sv | 93 +++++++++
 tb/tb_bcd2ex3_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2ex3_seq.sv
// Packed-BCD to excess-3 encoder, one digit per clock, LSD first.
// Digits above 9 encode as 0 and raise their bit in err_mask.
module bcd2ex3_seq #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_ex3,
  output logic [NDIG-1:0]   err_mask,
  output logic              out_err,
  output logic              busy
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [4*NDIG-1:0] src;
  logic              last;
  logic [3:0]        dig;
  logic [3:0]        dig_ex3;
  logic              dig_bad;

  assign last     = (cnt == CW'(NDIG - 1));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign out_err  = |err_mask;

  always_comb begin
    dig = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) dig = src[4*i +: 4];
    end
  end

  assign dig_bad = (dig > 4'd9);
  assign dig_ex3 = dig_bad ? 4'd0 : dig + 4'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src      <= '0;
      out_ex3  <= '0;
      err_mask <= '0;
      cnt      <= '0;
    end else if (state == IDLE && in_valid) begin
      src      <= in_bcd;
      out_ex3  <= '0;
      err_mask <= '0;
      cnt      <= '0;
    end else if (state == CONV) begin
      for (int i = 0; i < NDIG; i++) begin
        if (cnt == CW'(i)) begin
          out_ex3[4*i +: 4] <= dig_ex3;
          err_mask[i]       <= dig_bad;
        end
      end
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd2ex3_seq.sv
// Bench for bcd2ex3_seq: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_bcd2ex3_seq;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_bcd;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_ex3;
  logic [NDIG-1:0] err_mask;
  logic            out_err;
  logic            busy;

  bcd2ex3_seq #(.NDIG(NDIG)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bcd(in_bcd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ex3(out_ex3),
    .err_mask(err_mask),
    .out_err(out_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ex3_of(input logic [W-1:0] w);
    logic [3:0] d;
    ex3_of = '0;
    for (int i = 0; i < NDIG; i++) begin
      d = w[4*i +: 4];
      ex3_of[4*i +: 4] = (d < 4'd10) ? d + 4'd3 : 4'd0;
    end
  endfunction

  function automatic logic [NDIG-1:0] mask_of(input logic [W-1:0] w);
    mask_of = '0;
    for (int i = 0; i < NDIG; i++) mask_of[i] = (w[4*i +: 4] > 4'd9);
  endfunction

  // Transaction model: a word accepted now appears NDIG edges later
  // and stays until taken; the result lingers afterwards.
  int              m_left;
  logic            m_valid;
  logic [W-1:0]    m_word;
  logic [W-1:0]    m_ex3;
  logic [NDIG-1:0] m_mask;
  logic            m_busy;

  assign m_busy = (m_left != 0) || m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_word  <= '0;
      m_ex3   <= '0;
      m_mask  <= '0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_ex3   <= ex3_of(m_word);
        m_mask  <= mask_of(m_word);
      end
    end else if (in_valid) begin
      m_left <= NDIG;
      m_word <= in_bcd;
      m_ex3  <= '0;
      m_mask <= '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_left == 0) begin
        check("out_ex3", 64'(out_ex3), 64'(m_ex3));
        check("err_mask", 64'(err_mask), 64'(m_mask));
        check("out_err", 64'(out_err), 64'(|m_mask));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 64'(in_ready), 64'(1));
    in_bcd   = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check("latency", 64'(n), 64'(NDIG));
  endtask

  task automatic check_reset();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_ex3", 64'(out_ex3), 64'(0));
    check("rst_err_mask", 64'(err_mask), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    #12;
    check_reset();
    #1 rst_n = 1'b1;
    tick();

    // all zeros
    send(16'h0000);
    wait_out();
    check("zero_ex3", 64'(out_ex3), 64'h3333);
    check("zero_mask", 64'(err_mask), 64'h0);
    check("zero_err", 64'(out_err), 64'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("zero_drop", 64'(out_valid), 64'h0);
    check("zero_ready", 64'(in_ready), 64'h1);

    // out_ready tied high: one-cycle valid
    out_ready = 1'b1;
    send(16'h9876);
    wait_out();
    check("9876_ex3", 64'(out_ex3), 64'hCBA9);
    tick();
    check("9876_drop", 64'(out_valid), 64'h0);
    check("9876_ready", 64'(in_ready), 64'h1);
    check("9876_hold", 64'(out_ex3), 64'hCBA9);

    // error digits
    send(16'h12A4);
    wait_out();
    check("12A4_ex3", 64'(out_ex3), 64'h4507);
    check("12A4_mask", 64'(err_mask), 64'h2);
    check("12A4_err", 64'(out_err), 64'h1);
    tick();
    send(16'hFFFF);
    wait_out();
    check("FFFF_ex3", 64'(out_ex3), 64'h0);
    check("FFFF_mask", 64'(err_mask), 64'hF);
    check("FFFF_err", 64'(out_err), 64'h1);
    tick();
    out_ready = 1'b0;

    // backpressure with an ignored word
    send(16'h0123);
    wait_out();
    repeat (6) begin
      in_valid = 1'b1;
      in_bcd   = 16'h9999;
      tick();
      check("stall_valid", 64'(out_valid), 64'h1);
      check("stall_ready", 64'(in_ready), 64'h0);
      check("stall_ex3", 64'(out_ex3), 64'h3456);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_drop", 64'(out_valid), 64'h0);
    check("stall_keep", 64'(out_ex3), 64'h3456);
    tick();
    check("stall_idle", 64'(busy), 64'h0);

    // back-to-back with in_valid held
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 16'h0001;
    tick();
    check("b2b_acc1", 64'(busy), 64'h1);
    in_bcd = 16'h0009;
    wait_out();
    check("b2b_ex3_1", 64'(out_ex3), 64'h3334);
    tick();
    check("b2b_ready", 64'(in_ready), 64'h1);
    tick();
    check("b2b_acc2", 64'(busy), 64'h1);
    in_valid = 1'b0;
    wait_out();
    check("b2b_ex3_2", 64'(out_ex3), 64'h333C);
    tick();
    out_ready = 1'b0;

    // async reset mid-conversion
    send(16'h5555);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1 check_reset();
    #2 rst_n = 1'b1;
    send(16'h4321);
    wait_out();
    check("post_rst_ex3", 64'(out_ex3), 64'h7654);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // random traffic, checked by the model every cycle
    repeat (600) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < NDIG; i++) begin
        if ($urandom_range(0, 5) == 0)
          in_bcd[4*i +: 4] = 4'($urandom_range(10, 15));
        else
          in_bcd[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
